// File: rtl/hub_div_iterative.sv
// Iterative HUB floating-point divider.
// One restoring-division quotient bit per cycle, then a single normalise/pack
// cycle. Operands whose class decides the answer outright bypass the
// iteration and return the externally supplied special result.
module hub_div_iterative #(
    parameter int M            = 23,
    parameter int E            = 8,
    parameter int special_case = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [E+M:0]                     X,
    input  logic [E+M:0]                     Y,
    input  logic [$clog2(special_case)-1:0]  X_special_case,
    input  logic [$clog2(special_case)-1:0]  Y_special_case,
    input  logic [E+M:0]                     special_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [E+M:0]                     Z,
    output logic                             busy
);

    localparam int SCW = $clog2(special_case);
    localparam int CW  = $clog2(M + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic signed [E+1:0] EZ_BIAS = (E+2)'((1 << (E - 1)) - 1);
    localparam logic signed [E+1:0] EZ_MAX  = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] EZ_ZERO = '0;

    logic [1:0]    state_q, state_d;
    logic [E-1:0]  ex_q, ex_d;
    logic [E-1:0]  ey_q, ey_d;
    logic [M-1:0]  ym_q, ym_d;
    logic          sign_q, sign_d;
    logic [M+2:0]  rem_q, rem_d;
    logic [M+1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [E+M:0]  z_q, z_d;

    logic                accept;
    logic                take_special;
    logic [M+2:0]        divisor;
    logic [M+2:0]        partial;
    logic                qbit;
    logic [M-1:0]        mant;
    logic                adj;
    logic signed [E+1:0] ez;
    logic [E+M:0]        packed_z;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign Z         = z_q;

    // Divisor class non-zero, or dividend infinite/zero, means the answer is known up front.
    assign take_special = (Y_special_case != '0) ||
                          ((X_special_case >= SCW'(1)) && (X_special_case <= SCW'(4)));

    // Restoring step, normalisation and exponent/pack datapath.
    always_comb begin
        divisor = {1'b0, 1'b1, ym_q, 1'b1};
        qbit    = (rem_q >= divisor);
        partial = qbit ? (rem_q - divisor) : rem_q;

        if (quo_q[M+1]) begin
            mant = quo_q[M:1];
            adj  = 1'b0;
        end else begin
            mant = quo_q[M-1:0];
            adj  = 1'b1;
        end

        ez = $signed({2'b00, ex_q}) - $signed({2'b00, ey_q}) + EZ_BIAS
             - $signed({{(E+1){1'b0}}, adj});

        if (ez >= EZ_MAX) begin
            packed_z = {sign_q, {(E+M){1'b1}}};
        end else if (ez <= EZ_ZERO) begin
            packed_z = {sign_q, {(E+M){1'b0}}};
        end else begin
            packed_z = {sign_q, ez[E-1:0], mant};
        end
    end

    // Next-state and register-update logic for the IDLE/ITER/NORM/DONE sequencer.
    always_comb begin
        state_d = state_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        ym_d    = ym_q;
        sign_d  = sign_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        z_d     = z_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ex_d   = X[E+M-1:M];
                    ey_d   = Y[E+M-1:M];
                    ym_d   = Y[M-1:0];
                    sign_d = X[E+M] ^ Y[E+M];
                    if (take_special) begin
                        z_d     = special_result;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = {1'b0, 1'b1, X[M-1:0], 1'b1};
                        quo_d   = '0;
                        cnt_d   = CW'(M + 1);
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                rem_d = {partial[M+1:0], 1'b0};
                quo_d = {quo_q[M:0], qbit};
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_NORM: begin
                z_d     = packed_z;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; synchronous reset wins over accept and output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ex_q    <= '0;
            ey_q    <= '0;
            ym_q    <= '0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            ym_q    <= ym_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_hub_div_iterative.sv
// Testbench for hub_div_iterative: directed and randomized operations checked
// against an arithmetic model of the HUB quotient and the handshake timing.
module tb_hub_div_iterative;

    localparam int M_P = 23;
    localparam int E_P = 8;
    localparam int N_RANDOM = 1500;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [2:0]  x_sc;
    logic [2:0]  y_sc;
    logic [31:0] sr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z_out;
    logic        busy;

    int          n_checks;
    int          n_errors;
    int          cyc;
    bit          check_en;
    bit          exp_pending;
    int          exp_due;
    logic [31:0] exp_z;

    hub_div_iterative #(.M(M_P), .E(E_P), .special_case(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .X              (x_in),
        .Y              (y_in),
        .X_special_case (x_sc),
        .Y_special_case (y_sc),
        .special_result (sr_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .Z              (z_out),
        .busy           (busy)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference quotient computed directly from the HUB division rules.
    function automatic logic [31:0] modelDiv(input logic [31:0] x, input logic [31:0] y,
                                             input logic [2:0] xc, input logic [2:0] yc,
                                             input logic [31:0] sr);
        longint a, b, q, mant;
        int     adj, ez;
        logic   s;
        if (yc != 3'd0 || (xc >= 3'd1 && xc <= 3'd4)) return sr;
        s = x[31] ^ y[31];
        a = (longint'(1) << 24) + longint'(x[22:0]) * 2 + 1;
        b = (longint'(1) << 24) + longint'(y[22:0]) * 2 + 1;
        q = (a << 24) / b;
        if (q >= (longint'(1) << 24)) begin
            mant = (q >> 1) % (longint'(1) << 23);
            adj  = 0;
        end else begin
            mant = q % (longint'(1) << 23);
            adj  = 1;
        end
        ez = int'(x[30:23]) - int'(y[30:23]) + 127 - adj;
        if (ez >= 255) return {s, 31'h7FFF_FFFF};
        if (ez <= 0) return {s, 31'h0};
        return {s, ez[7:0], mant[22:0]};
    endfunction

    function automatic int modelLatency(input logic [2:0] xc, input logic [2:0] yc);
        if (yc != 3'd0 || (xc >= 3'd1 && xc <= 3'd4)) return 1;
        return M_P + 4;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Per-cycle comparison of the DUT outputs against the expected transaction.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("out_valid", 64'(out_valid), 64'(exp_pending && cyc >= exp_due));
            checkOutput("busy", 64'(busy), 64'(exp_pending));
            checkOutput("in_ready", 64'(in_ready), 64'(!exp_pending && !rst));
            if (exp_pending && cyc >= exp_due)
                checkOutput("Z", 64'(z_out), 64'(exp_z));
        end
    end

    // Present operands, wait for the handshake edge and publish the expectation.
    task automatic acceptOp(input logic [31:0] x, input logic [31:0] y,
                            input logic [2:0] xc, input logic [2:0] yc,
                            input logic [31:0] sr, output int acc_cyc);
        x_in     = x;
        y_in     = y;
        x_sc     = xc;
        y_sc     = yc;
        sr_in    = sr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        exp_z       = modelDiv(x, y, xc, yc, sr);
        exp_due     = cyc + modelLatency(xc, yc) - 1;
        exp_pending = 1'b1;
        acc_cyc     = cyc;
        x_in        = $urandom;
        y_in        = $urandom;
        sr_in       = $urandom;
    endtask

    // Full operation: accept, wait for out_valid, stall the consumer, then retire.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic [2:0] xc, input logic [2:0] yc,
                                 input logic [31:0] sr, input int stall,
                                 output logic [31:0] z_seen, output int lat_seen);
        int acc;
        acceptOp(x, y, xc, yc, sr, acc);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!out_valid) begin
            checkOutput("timeout", 64'(0), 64'(1));
            rst = 1'b1;
            @(posedge clk);
            #1;
            exp_pending = 1'b0;
            rst = 1'b0;
            z_seen = 'x;
            lat_seen = -1;
            return;
        end
        lat_seen = cyc - acc + 1;
        z_seen   = z_out;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x_in     = $urandom;
            y_in     = $urandom;
            sr_in    = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready   = 1'b0;
        exp_pending = 1'b0;
        checkOutput("in_ready_after_handshake", 64'(in_ready), 64'(1));
    endtask

    task automatic directedOp(input string name, input logic [31:0] x, input logic [31:0] y,
                              input logic [2:0] xc, input logic [2:0] yc,
                              input logic [31:0] sr, input int stall,
                              input logic [31:0] want_z, input int want_lat);
        logic [31:0] z_seen;
        int          lat_seen;
        checkOutput({name, "_model"}, 64'(modelDiv(x, y, xc, yc, sr)), 64'(want_z));
        applyStimulus(x, y, xc, yc, sr, stall, z_seen, lat_seen);
        checkOutput({name, "_z"}, 64'(z_seen), 64'(want_z));
        checkOutput({name, "_latency"}, 64'(lat_seen), 64'(want_lat));
    endtask

    initial begin
        logic [31:0] z_seen;
        int          lat_seen;
        int          acc;
        logic [31:0] rx, ry, rsr;
        logic [2:0]  rxc, ryc;
        int          kind;

        n_checks    = 0;
        n_errors    = 0;
        cyc         = 0;
        check_en    = 1'b0;
        exp_pending = 1'b0;
        exp_due     = 0;
        exp_z       = '0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        x_in        = '0;
        y_in        = '0;
        x_sc        = '0;
        y_sc        = '0;
        sr_in       = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_z", 64'(z_out), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'(1));
        check_en = 1'b1;

        directedOp("one_by_one", 32'h4000_0000, 32'h4000_0000, 3'd0, 3'd0, 32'h0, 0, 32'h3F80_0000, 27);
        directedOp("neg_sign", 32'hC000_0000, 32'h4000_0000, 3'd0, 3'd0, 32'h0, 1, 32'hBF80_0000, 27);
        directedOp("overflow", 32'h7F00_0000, 32'h0080_0000, 3'd0, 3'd0, 32'h0, 0, 32'h7FFF_FFFF, 27);
        directedOp("underflow", 32'h0080_0000, 32'h7F00_0000, 3'd0, 3'd0, 32'h0, 2, 32'h0000_0000, 27);
        directedOp("hub_trunc", 32'h4040_0000, 32'h4000_0000, 3'd0, 3'd0, 32'h0, 0, 32'h3FBF_FFFF, 27);
        directedOp("special_y0", 32'h1234_5678, 32'h0000_0000, 3'd0, 3'd3, 32'h7FFF_FFFF, 10, 32'h7FFF_FFFF, 1);
        directedOp("x_is_one", 32'h3F80_0000, 32'h4000_0000, 3'd5, 3'd0, 32'hDEAD_BEEF, 0, 32'h3F00_0000, 27);

        // Abort in the tenth iteration cycle, then confirm a clean restart.
        acceptOp(32'h4040_0000, 32'h4000_0000, 3'd0, 3'd0, 32'h0, acc);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_pending = 1'b0;
        checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_z", 64'(z_out), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", 64'(in_ready), 64'(1));
        directedOp("after_abort", 32'h4000_0000, 32'h4000_0000, 3'd0, 3'd0, 32'h0, 0, 32'h3F80_0000, 27);

        for (int n = 0; n < N_RANDOM; n++) begin
            kind = $urandom_range(0, 9);
            rx   = $urandom;
            ry   = $urandom;
            rsr  = $urandom;
            rxc  = 3'd0;
            ryc  = 3'd0;
            if (kind < 5) begin
                rx[30:23] = 8'($urandom_range(64, 191));
                ry[30:23] = 8'($urandom_range(64, 191));
            end else if (kind == 7) begin
                rxc = 3'($urandom_range(5, 6));
            end else if (kind == 8) begin
                rxc = 3'($urandom_range(1, 4));
            end else if (kind == 9) begin
                ryc = 3'($urandom_range(1, 6));
            end
            applyStimulus(rx, ry, rxc, ryc, rsr, $urandom_range(0, 3), z_seen, lat_seen);
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
